// File: rtl/sindoku_pkg.sv
// sindoku_pkg: one-hot engine states and linear cell-index helpers.
package sindoku_pkg;

   typedef enum logic [5:0] {
      I         = 6'b000001,
      LOAD      = 6'b000010,
      SOLVE     = 6'b000100,
      CHECK     = 6'b001000,
      CORRECT   = 6'b010000,
      INCORRECT = 6'b100000
   } state_e;

   function automatic int idx(input int row, input int col, input int n);
      return row * n + col;
   endfunction

   function automatic int idx_row(input int a, input int n);
      return a / n;
   endfunction

   function automatic int idx_col(input int a, input int n);
      return a % n;
   endfunction

endpackage

// File: rtl/sindoku_cursor.sv
// sindoku_cursor: row/col cursor with saturating moves; opposite presses cancel.
module sindoku_cursor #(
   parameter int N  = 9,
   parameter int VW = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic          r_i,
   input  logic          l_i,
   input  logic          u_i,
   input  logic          d_i,
   output logic [VW-1:0] row_o,
   output logic [VW-1:0] col_o
);

   logic [VW-1:0] row_q, row_d, col_q, col_d;

   always_comb begin
      col_d = (r_i && !l_i && col_q != VW'(N-1)) ? col_q + 1'b1 :
              (l_i && !r_i && col_q != '0)        ? col_q - 1'b1 : col_q;
      row_d = (d_i && !u_i && row_q != VW'(N-1)) ? row_q + 1'b1 :
              (u_i && !d_i && row_q != '0)        ? row_q - 1'b1 : row_q;
   end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         row_q <= '0;
         col_q <= '0;
      end else if (clr_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (en_i) begin
         row_q <= row_d;
         col_q <= col_d;
      end

   assign row_o = row_q;
   assign col_o = col_q;

endmodule

// File: rtl/sindoku_engine.sv
// sindoku_engine: BOX*BOX Sudoku engine - ROM load, clue locking, cursor edits, solution scan.
// Define SINDOKU_ERRCNT_EN to scan the whole grid on CHECK and report err_count.
module sindoku_engine
   import sindoku_pkg::*;
#(
   parameter int BOX = 3,
   parameter int VW  = $clog2(BOX*BOX+1),
   parameter int AW  = $clog2(BOX**4)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          BtnR,
   input  logic          BtnL,
   input  logic          BtnU,
   input  logic          BtnD,
   input  logic          BtnC,
   input  logic          CheckSolu,
   input  logic          Ack,
   input  logic [VW-1:0] UserIn,
   output logic [AW-1:0] rom_addr,
   input  logic [VW-1:0] rom_puz,
   input  logic [VW-1:0] rom_sol,
   input  logic [VW-1:0] rd_row,
   input  logic [VW-1:0] rd_col,
   output logic [VW-1:0] rd_val,
   output logic          rd_given,
   output logic [VW-1:0] cur_row,
   output logic [VW-1:0] cur_col,
   output logic [VW-1:0] err_row,
   output logic [VW-1:0] err_col,
`ifdef SINDOKU_ERRCNT_EN
   output logic [AW:0]   err_count,
`endif
   output logic          q_I,
   output logic          q_Load,
   output logic          q_Solve,
   output logic          q_Check,
   output logic          q_Correct,
   output logic          q_Incorrect
);

   localparam int N  = BOX * BOX;
   localparam int NN = N * N;

   state_e        state_q, state_d;
   logic [VW-1:0] grid_q [NN];
   logic [VW-1:0] sol_q  [NN];
   logic [NN-1:0] given_q;
   logic [AW-1:0] rom_addr_q, cur_a, k_a, ld_a, rd_a;
   logic [AW:0]   k_q;
   logic [VW-1:0] err_row_q, err_col_q;
   logic          mis, last, load_done, wr_en, rd_ok, err_first;

   sindoku_cursor #(.N(N), .VW(VW)) u_cursor (
      .Clk   (Clk),
      .Reset (Reset),
      .clr_i (load_done),
      .en_i  (state_q == SOLVE && !CheckSolu),
      .r_i   (BtnR),
      .l_i   (BtnL),
      .u_i   (BtnU),
      .d_i   (BtnD),
      .row_o (cur_row),
      .col_o (cur_col)
   );

   // k_q counts LOAD cycles (write index lags by one) and is the CHECK scan index
   assign k_a       = k_q[AW-1:0];
   assign ld_a      = AW'(k_q - 1'b1);
   assign cur_a     = AW'(idx(int'(cur_row), int'(cur_col), N));
   assign mis       = grid_q[k_a] == '0 || grid_q[k_a] != sol_q[k_a];
   assign last      = k_q == (AW+1)'(NN-1);
   assign load_done = state_q == LOAD && k_q == (AW+1)'(NN);
   assign wr_en     = state_q == SOLVE && !CheckSolu && BtnC && !given_q[cur_a] && UserIn <= VW'(N);
   assign rd_ok     = rd_row < VW'(N) && rd_col < VW'(N);
   assign rd_a      = rd_ok ? AW'(idx(int'(rd_row), int'(rd_col), N)) : '0;
   assign rd_val    = rd_ok ? grid_q[rd_a] : '0;
   assign rd_given  = rd_ok && given_q[rd_a];

`ifdef SINDOKU_ERRCNT_EN
   logic [AW:0] err_count_q;
   assign err_first = err_count_q == '0;
   assign err_count = err_count_q;
`else
   assign err_first = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         I:         if (Start) state_d = LOAD;
         LOAD:      if (load_done) state_d = SOLVE;
         SOLVE:     if (CheckSolu) state_d = CHECK;
`ifdef SINDOKU_ERRCNT_EN
         CHECK:     if (last) state_d = (err_count_q == '0 && !mis) ? CORRECT : INCORRECT;
`else
         CHECK:     state_d = mis ? INCORRECT : last ? CORRECT : CHECK;
`endif
         CORRECT:   if (Ack) state_d = I;
         INCORRECT: if (Ack) state_d = SOLVE;
         default:   state_d = I;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) state_q <= I;
      else       state_q <= state_d;

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         rom_addr_q <= '0;
         k_q        <= '0;
         err_row_q  <= '0;
         err_col_q  <= '0;
         given_q    <= '0;
         for (int i = 0; i < NN; i++) begin
            grid_q[i] <= '0;
            sol_q[i]  <= '0;
         end
`ifdef SINDOKU_ERRCNT_EN
         err_count_q <= '0;
`endif
      end else begin
         if (state_q == I && Start) begin
            rom_addr_q <= '0;
            k_q        <= '0;
         end
         if (state_q == LOAD) begin
            k_q <= k_q + 1'b1;
            if (rom_addr_q != AW'(NN-1)) rom_addr_q <= rom_addr_q + 1'b1;
            if (k_q != '0) begin
               grid_q[ld_a]  <= rom_puz;
               sol_q[ld_a]   <= rom_sol;
               given_q[ld_a] <= rom_puz != '0;
            end
         end
         if (wr_en) grid_q[cur_a] <= UserIn;
         if (state_q == SOLVE && CheckSolu) begin
            k_q <= '0;
`ifdef SINDOKU_ERRCNT_EN
            err_count_q <= '0;
`endif
         end
         if (state_q == CHECK) begin
            k_q <= k_q + 1'b1;
            if (mis && err_first) begin
               err_row_q <= VW'(idx_row(int'(k_a), N));
               err_col_q <= VW'(idx_col(int'(k_a), N));
            end
`ifdef SINDOKU_ERRCNT_EN
            err_count_q <= err_count_q + (AW+1)'(mis);
`endif
         end
      end

   assign rom_addr    = rom_addr_q;
   assign err_row     = err_row_q;
   assign err_col     = err_col_q;
   assign q_I         = state_q == I;
   assign q_Load      = state_q == LOAD;
   assign q_Solve     = state_q == SOLVE;
   assign q_Check     = state_q == CHECK;
   assign q_Correct   = state_q == CORRECT;
   assign q_Incorrect = state_q == INCORRECT;

endmodule

// File: tb/tb_sindoku_engine.sv
// tb_sindoku_engine: BOX=2 engine for load/cursor/edit behaviour, BOX=3 engine for solution checks.
module tb_sindoku_engine;

   typedef struct {logic ok; int row; int col; int lat;} res_t;

   logic Clk = 1'b0, Reset = 1'b1;
   int   errors = 0, checks = 0;
   int   sb[$];
   res_t rq[$];

   always #5 Clk = ~Clk;

   logic       st2 = 0, br2 = 0, bl2 = 0, bu2 = 0, bd2 = 0, bc2 = 0, ck2 = 0, ak2 = 0;
   logic [2:0] ui2 = '0, rr2 = '0, rc2 = '0, rp2, rs2, rv2, cr2, cc2, er2, ec2;
   logic [3:0] ra2;
   logic       rg2;
   logic [5:0] f2;
   logic [2:0] puz2 [16] = '{3'd1, 3'd0, 3'd3, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0,
                             3'd0, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 3'd1};
   logic [2:0] sol2 [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd2,
                             3'd2, 3'd1, 3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};

   logic       st3 = 0, br3 = 0, bl3 = 0, bu3 = 0, bd3 = 0, bc3 = 0, ck3 = 0, ak3 = 0;
   logic [3:0] ui3 = '0, rr3 = '0, rc3 = '0, rp3, rs3, rv3, cr3, cc3, er3, ec3;
   logic [6:0] ra3;
   logic       rg3;
   logic [5:0] f3;
   logic [3:0] puz3 [81], sol3 [81];
`ifdef SINDOKU_ERRCNT_EN
   logic [4:0] cnt2;
   logic [7:0] cnt3;
`endif

   always @(posedge Clk) begin
      rp2 <= puz2[ra2];
      rs2 <= sol2[ra2];
      rp3 <= puz3[ra3];
      rs3 <= sol3[ra3];
   end

   sindoku_engine #(.BOX(2)) u2 (
      .Clk(Clk), .Reset(Reset), .Start(st2), .BtnR(br2), .BtnL(bl2), .BtnU(bu2), .BtnD(bd2),
      .BtnC(bc2), .CheckSolu(ck2), .Ack(ak2), .UserIn(ui2), .rom_addr(ra2), .rom_puz(rp2),
      .rom_sol(rs2), .rd_row(rr2), .rd_col(rc2), .rd_val(rv2), .rd_given(rg2), .cur_row(cr2),
      .cur_col(cc2), .err_row(er2), .err_col(ec2),
`ifdef SINDOKU_ERRCNT_EN
      .err_count(cnt2),
`endif
      .q_I(f2[0]), .q_Load(f2[1]), .q_Solve(f2[2]), .q_Check(f2[3]), .q_Correct(f2[4]),
      .q_Incorrect(f2[5])
   );

   sindoku_engine #(.BOX(3)) u3 (
      .Clk(Clk), .Reset(Reset), .Start(st3), .BtnR(br3), .BtnL(bl3), .BtnU(bu3), .BtnD(bd3),
      .BtnC(bc3), .CheckSolu(ck3), .Ack(ak3), .UserIn(ui3), .rom_addr(ra3), .rom_puz(rp3),
      .rom_sol(rs3), .rd_row(rr3), .rd_col(rc3), .rd_val(rv3), .rd_given(rg3), .cur_row(cr3),
      .cur_col(cc3), .err_row(er3), .err_col(ec3),
`ifdef SINDOKU_ERRCNT_EN
      .err_count(cnt3),
`endif
      .q_I(f3[0]), .q_Load(f3[1]), .q_Solve(f3[2]), .q_Check(f3[3]), .q_Correct(f3[4]),
      .q_Incorrect(f3[5])
   );

   function automatic logic [3:0] sol3v(input int r, input int c);
      return 4'((r * 3 + r / 3 + c) % 9 + 1);
   endfunction

   function automatic logic [3:0] wrong(input logic [3:0] v);
      return v == 4'd9 ? 4'd1 : v + 4'd1;
   endfunction

   task automatic press2(input logic r, input logic l, input logic u, input logic d, input logic c);
      {br2, bl2, bu2, bd2, bc2} = {r, l, u, d, c};
      @(negedge Clk);
      {br2, bl2, bu2, bd2, bc2} = '0;
   endtask

   task automatic press3(input logic r, input logic l, input logic u, input logic d, input logic c);
      {br3, bl3, bu3, bd3, bc3} = {r, l, u, d, c};
      @(negedge Clk);
      {br3, bl3, bu3, bd3, bc3} = '0;
   endtask

   task automatic write3(input int r, input int c, input logic [3:0] v);
      repeat (8) press3(0, 1, 1, 0, 0);
      repeat (r) press3(0, 0, 0, 1, 0);
      repeat (c) press3(1, 0, 0, 0, 0);
      ui3 = v;
      press3(0, 0, 0, 0, 1);
   endtask

   task automatic fill3(input bit bad);
      write3(4, 6, bad ? wrong(sol3v(4, 6)) : sol3v(4, 6));
      write3(1, 2, sol3v(1, 2));
      write3(7, 7, sol3v(7, 7));
      write3(8, 0, sol3v(8, 0));
   endtask

   task automatic load3();
      int n = 0;
      st3 = 1;
      @(negedge Clk);
      st3 = 0;
      while (!f3[2] && n < 200) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (f3 !== 6'b000100) begin
         errors++;
         $display("FAIL load3_reach_solve: state=%b required 000100", f3);
      end
   endtask

   task automatic run_check3(input logic ok, input int row, input int col, input int lat);
      int   n = 0;
      res_t r;
      rq.push_back('{ok, row, col, lat});
      ck3 = 1;
      @(negedge Clk);
      ck3 = 0;
      while (f3[3] && n < 300) begin
         n++;
         @(negedge Clk);
      end
      r = rq.pop_front();
      checks++;
      if (f3 !== (r.ok ? 6'b010000 : 6'b100000)) begin
         errors++;
         $display("FAIL check3_result: state=%b required %b", f3, r.ok ? 6'b010000 : 6'b100000);
      end
      if (!r.ok) begin
         checks++;
         if ({er3, ec3} !== {4'(r.row), 4'(r.col)}) begin
            errors++;
            $display("FAIL check3_err_cell: got (%0d,%0d) required (%0d,%0d)", er3, ec3, r.row, r.col);
         end
      end
      if (r.lat >= 0) begin
         checks++;
         if (n != r.lat) begin
            errors++;
            $display("FAIL check3_latency: got %0d cycles required %0d", n, r.lat);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      checks++;
      if (f2 !== 6'b000001 || f3 !== 6'b000001) begin
         errors++;
         $display("FAIL reset_state: got %b/%b required 000001", f2, f3);
      end
      checks++;
      if ({cr3, cc3, er3, ec3, ra3} !== '0) begin
         errors++;
         $display("FAIL reset_regs: cur=(%0d,%0d) err=(%0d,%0d) addr=%0d required all 0", cr3, cc3, er3, ec3, ra3);
      end
      Reset = 0;
      @(negedge Clk);
      checks++;
      if (f2 !== 6'b000001 || rv2 !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_reset: state=%b val=%0d required 000001/0", f2, rv2);
      end
   endtask

   task automatic test_load2();
      int n = 0;
      int e;
      st2 = 1;
      @(negedge Clk);
      st2 = 0;
      checks++;
      if (f2 !== 6'b000010) begin
         errors++;
         $display("FAIL load2_enter: state=%b required 000010", f2);
      end
      while (!f2[2] && n < 100) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (n != 17 || f2 !== 6'b000100) begin
         errors++;
         $display("FAIL load2_cycles: got %0d state=%b required 17 000100", n, f2);
      end
      checks++;
      if ({cr2, cc2} !== 6'd0) begin
         errors++;
         $display("FAIL load2_cursor: got (%0d,%0d) required (0,0)", cr2, cc2);
      end
      for (int i = 0; i < 16; i++) begin
         sb.push_back(int'(puz2[i]));
         sb.push_back(puz2[i] != 3'd0 ? 1 : 0);
      end
      for (int i = 0; i < 16; i++) begin
         rr2 = 3'(i / 4);
         rc2 = 3'(i % 4);
         #1;
         e = sb.pop_front();
         checks++;
         if (int'(rv2) != e) begin
            errors++;
            $display("FAIL load2_val[%0d]: got %0d required %0d", i, rv2, e);
         end
         e = sb.pop_front();
         checks++;
         if (int'(rg2) != e) begin
            errors++;
            $display("FAIL load2_given[%0d]: got %0d required %0d", i, rg2, e);
         end
      end
      rr2 = 3'd4;
      rc2 = 3'd0;
      #1;
      checks++;
      if (rv2 !== 3'd0 || rg2 !== 1'b0) begin
         errors++;
         $display("FAIL rd_out_of_range: got val=%0d given=%0d required 0/0", rv2, rg2);
      end
      @(negedge Clk);
   endtask

   task automatic test_cursor2();
      logic [3:0] mv [11] = '{4'b0100, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                              4'b1100, 4'b0011, 4'b0101, 4'b0010};
      logic [5:0] ex [11] = '{6'o00, 6'o00, 6'o01, 6'o02, 6'o03, 6'o03, 6'o03,
                              6'o03, 6'o03, 6'o12, 6'o02};
      for (int i = 0; i < 11; i++) begin
         press2(mv[i][3], mv[i][2], mv[i][1], mv[i][0], 1'b0);
         checks++;
         if ({cr2, cc2} !== ex[i]) begin
            errors++;
            $display("FAIL cursor_step%0d: got (%0d,%0d) required (%0d,%0d)", i, cr2, cc2, ex[i][5:3], ex[i][2:0]);
         end
      end
   endtask

   task automatic test_btnc2();
      int e;
      rr2 = 3'd0;
      rc2 = 3'd2;
      ui2 = 3'd4;
      sb.push_back(3);
      press2(0, 0, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (int'(rv2) != e) begin
         errors++;
         $display("FAIL btnc_given_locked: got %0d required %0d", rv2, e);
      end
      press2(0, 0, 0, 1, 0);
      rr2 = 3'd1;
      sb.push_back(4);
      press2(0, 0, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (int'(rv2) != e) begin
         errors++;
         $display("FAIL btnc_write: got %0d required %0d", rv2, e);
      end
      ui2 = 3'd7;
      sb.push_back(4);
      press2(0, 0, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (int'(rv2) != e) begin
         errors++;
         $display("FAIL btnc_over_range: got %0d required %0d", rv2, e);
      end
      ui2 = 3'd0;
      sb.push_back(0);
      press2(1, 0, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (int'(rv2) != e || {cr2, cc2} !== 6'o13) begin
         errors++;
         $display("FAIL btnc_premove_clear: val=%0d cur=(%0d,%0d) required %0d (1,3)", rv2, cr2, cc2, e);
      end
   endtask

   task automatic test_priority2();
      int n = 0;
      ui2 = 3'd2;
      {ck2, br2, bc2} = 3'b111;
      @(negedge Clk);
      {ck2, br2, bc2} = 3'b000;
      rr2 = 3'd1;
      rc2 = 3'd3;
      #1;
      checks++;
      if (f2 !== 6'b001000 || {cr2, cc2} !== 6'o13 || rv2 !== 3'd0) begin
         errors++;
         $display("FAIL check_priority: state=%b cur=(%0d,%0d) val=%0d required 001000 (1,3) 0", f2, cr2, cc2, rv2);
      end
      while (f2[3] && n < 100) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (f2 !== 6'b100000 || {er2, ec2} !== 6'o01) begin
         errors++;
         $display("FAIL check2_empty_err: state=%b err=(%0d,%0d) required 100000 (0,1)", f2, er2, ec2);
      end
      ak2 = 1;
      @(negedge Clk);
      ak2 = 0;
      checks++;
      if (f2 !== 6'b000100) begin
         errors++;
         $display("FAIL ack2_to_solve: state=%b required 000100", f2);
      end
   endtask

   task automatic test_check_correct3();
      load3();
      fill3(0);
      run_check3(1, 0, 0, 81);
      ak3 = 1;
      @(negedge Clk);
      ak3 = 0;
      rr3 = 4'd4;
      rc3 = 4'd6;
      #1;
      checks++;
      if (f3 !== 6'b000001 || rv3 !== sol3v(4, 6)) begin
         errors++;
         $display("FAIL correct_ack_to_I: state=%b val=%0d required 000001 %0d", f3, rv3, sol3v(4, 6));
      end
      @(negedge Clk);
   endtask

   task automatic test_check_incorrect3();
      logic [7:0] cur;
      load3();
      fill3(1);
      cur = {cr3, cc3};
      run_check3(0, 4, 6, -1);
      ak3 = 1;
      @(negedge Clk);
      ak3 = 0;
      rr3 = 4'd4;
      rc3 = 4'd6;
      #1;
      checks++;
      if (f3 !== 6'b000100 || {cr3, cc3} !== cur || rv3 !== wrong(sol3v(4, 6))) begin
         errors++;
         $display("FAIL incorrect_ack_resume: state=%b cur=%h val=%0d required 000100 %h %0d", f3, {cr3, cc3}, rv3, cur, wrong(sol3v(4, 6)));
      end
      @(negedge Clk);
   endtask

`ifdef SINDOKU_ERRCNT_EN
   task automatic test_errcnt3();
      write3(1, 2, wrong(sol3v(1, 2)));
      write3(7, 7, wrong(sol3v(7, 7)));
      write3(8, 0, 4'd0);
      run_check3(0, 1, 2, 81);
      checks++;
      if (cnt3 !== 8'd4) begin
         errors++;
         $display("FAIL errcnt_total: got %0d required 4", cnt3);
      end
      ak3 = 1;
      @(negedge Clk);
      ak3 = 0;
   endtask
`endif

   task automatic test_reset_mid_check3();
      int bad = 0;
      ck3 = 1;
      @(negedge Clk);
      ck3 = 0;
      repeat (4) @(negedge Clk);
      checks++;
      if (f3 !== 6'b001000) begin
         errors++;
         $display("FAIL midcheck_in_check: state=%b required 001000", f3);
      end
      Reset = 1;
      #1;
      checks++;
      if (f3 !== 6'b000001 || {cr3, cc3, er3, ec3, ra3} !== '0) begin
         errors++;
         $display("FAIL midcheck_reset: state=%b cur=(%0d,%0d) err=(%0d,%0d) required 000001 all 0", f3, cr3, cc3, er3, ec3);
      end
      @(negedge Clk);
      Reset = 0;
      for (int i = 0; i < 81; i++) begin
         rr3 = 4'(i / 9);
         rc3 = 4'(i % 9);
         #1;
         if (rv3 !== 4'd0 || rg3 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midcheck_grid_cleared: %0d nonzero cells required 0", bad);
      end
   endtask

   initial begin
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) begin
            sol3[r * 9 + c] = sol3v(r, c);
            puz3[r * 9 + c] = sol3v(r, c);
         end
      puz3[1 * 9 + 2] = 4'd0;
      puz3[4 * 9 + 6] = 4'd0;
      puz3[7 * 9 + 7] = 4'd0;
      puz3[8 * 9 + 0] = 4'd0;
      test_reset();
      test_load2();
      test_cursor2();
      test_btnc2();
      test_priority2();
      test_check_correct3();
      test_check_incorrect3();
`ifdef SINDOKU_ERRCNT_EN
      test_errcnt3();
`endif
      test_reset_mid_check3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
